// File: rtl/uart_angle_framer.sv
// Frames UART bytes (header, little-endian payload, XOR checksum) into an angle word
// and hands it to the CORDIC over valid/ready. Rejected frames pulse msg_err_o.
module uart_angle_framer #(
  parameter int         DATA_W      = 16,
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  input  logic              rx_err_i,
  output logic [DATA_W-1:0] angle_o,
  output logic              angle_valid_o,
  input  logic              angle_ready_i,
  output logic              msg_err_o,
  output logic              busy_o
);

  localparam int              NB       = DATA_W / 8;
  localparam int              TW       = $clog2(TIMEOUT_CYC);
  localparam logic [1:0]      LAST_IDX = 2'(NB - 1);
  localparam logic [TW-1:0]   TO_MAX   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_CHECK
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_shadow;
  logic [DATA_W-1:0]   r_angle;
  logic                r_valid;
  logic                r_err;
  logic [7:0]          r_csum;
  logic [1:0]          r_cnt;
  logic [TW-1:0]       r_to;

  logic w_good;
  logic w_timeout;
  logic w_start;
  logic w_take;
  logic w_commit;
  logic w_err;

  assign w_good    = rx_valid_i && !rx_err_i;
  assign w_timeout = (r_to == TO_MAX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A strobe always wins over the timeout in the same cycle.
  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_take   = 1'b0;
    w_commit = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_good && rx_data_i == HEADER) begin
          w_start = 1'b1;
          w_next  = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (rx_valid_i) begin
          if (rx_err_i) begin
            w_err  = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_take = 1'b1;
            if (r_cnt == LAST_IDX) begin
              w_next = S_CHECK;
            end
          end
        end else if (w_timeout) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_CHECK: begin
        if (rx_valid_i) begin
          w_next = S_IDLE;
          if (rx_err_i || rx_data_i != r_csum) begin
            w_err = 1'b1;
          end else if (!r_valid || angle_ready_i) begin
            w_commit = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end else if (w_timeout) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shadow <= '0;
      r_angle  <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_csum   <= '0;
      r_cnt    <= '0;
      r_to     <= '0;
    end else begin
      r_err <= w_err;

      // A commit landing on a handshake cycle replaces the consumed word.
      if (w_commit) begin
        r_angle <= r_shadow;
        r_valid <= 1'b1;
      end else if (r_valid && angle_ready_i) begin
        r_valid <= 1'b0;
      end

      if (w_start) begin
        r_csum <= HEADER;
        r_cnt  <= '0;
      end else if (w_take) begin
        r_csum <= r_csum ^ rx_data_i;
        r_cnt  <= r_cnt + 2'd1;
        for (int b = 0; b < NB; b++) begin
          if (r_cnt == 2'(b)) begin
            r_shadow[b*8 +: 8] <= rx_data_i;
          end
        end
      end

      if (w_next == S_IDLE || w_start || w_take) begin
        r_to <= '0;
      end else begin
        r_to <= r_to + 1'b1;
      end
    end
  end

  assign angle_o       = r_angle;
  assign angle_valid_o = r_valid;
  assign msg_err_o     = r_err;
  assign busy_o        = (r_state != S_IDLE);

endmodule

// File: doc/uart_angle_framer.md
Name: uart_angle_framer

Overview:
- Sits between the UART receiver and the CORDIC pipeline inside the UART/CORDIC datapath.
- Assembles received bytes into a framed angle word: header byte, payload bytes (little-endian), XOR checksum byte.
- Presents each validated word to the CORDIC over a valid/ready handshake.
- Flags malformed, corrupted, stalled or overrun frames on a message-error pulse that feeds the board-level message-error LED.

Parameters:
- DATA_W, 16, angle word width; must be a multiple of 8; payload byte count NB = DATA_W/8 (1..4).
- HEADER, 8'hA5, frame start byte.
- TIMEOUT_CYC, 4096, maximum clock cycles allowed between consecutive bytes of one frame; minimum 2.

Ports:
- clk_i  in  1  system clock, single clock domain.
- rst_ni  in  1  asynchronous active-low reset.
- rx_data_i  in  8  received byte from UART RX.
- rx_valid_i  in  1  one-cycle strobe; rx_data_i is valid.
- rx_err_i  in  1  parity/stop error for the byte on this strobe; qualified by rx_valid_i.
- angle_o  out  DATA_W  assembled angle word to CORDIC.
- angle_valid_o  out  1  angle_o holds an unconsumed word.
- angle_ready_i  in  1  CORDIC accepts the word when high together with angle_valid_o.
- msg_err_o  out  1  one-cycle pulse per rejected frame.
- busy_o  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (async assert, release sampled on clk_i):
  - state = IDLE; angle_o = 0; angle_valid_o = 0; msg_err_o = 0; busy_o = 0.
  - Byte counter, checksum accumulator and timeout counter = 0.
- States: IDLE, PAYLOAD, CHECK.
- IDLE:
  - Byte with rx_valid_i = 1, rx_err_i = 0 and rx_data_i == HEADER: checksum := HEADER; byte counter := 0; go to PAYLOAD.
  - All other bytes, including errored ones, are discarded silently; no msg_err_o.
- PAYLOAD:
  - Each valid byte is shifted into the shadow word at byte position = counter (first byte is the LSB).
  - checksum ^= byte; counter increments.
  - After NB bytes, go to CHECK.
- CHECK:
  - Next valid byte is compared with checksum.
  - On match, perform a commit attempt; return to IDLE in either case.
- Commit attempt:
  - If angle_valid_o = 0, or angle_valid_o = 1 and angle_ready_i = 1 in the same cycle: angle_o := shadow and angle_valid_o = 1 from the next cycle. Latency is 1 cycle after the checksum strobe.
  - Otherwise (output still held): overrun. The new frame is dropped, the held word is unchanged, and msg_err_o pulses.
- Handshake:
  - angle_valid_o clears the cycle after angle_valid_o && angle_ready_i, unless a commit lands in that same cycle.
  - angle_o is stable while angle_valid_o = 1 and angle_ready_i = 0.
- Frame errors: each returns to IDLE and pulses msg_err_o for 1 cycle, registered (asserted the cycle after the event).
  - rx_err_i = 1 on a strobe while in PAYLOAD or CHECK.
  - Checksum mismatch.
  - Timeout counter reaching TIMEOUT_CYC-1.
  - Overrun (see commit attempt).
- Timeout counter:
  - Counts only in PAYLOAD/CHECK.
  - Clears on every accepted byte and on entry to IDLE.
- An errored frame's bytes never reach angle_o.
- A byte equal to HEADER mid-frame is treated as ordinary data, not as resync.
- Back-to-back strobes (rx_valid_i on consecutive cycles) must be accepted without loss.
- Reset mid-frame discards the partial frame and any held output word; no msg_err_o is issued.

Test Plan:
- Bytes A5,34,12,83 with angle_ready_i = 1 -> angle_o = 16'h1234, angle_valid_o high exactly 1 cycle after the 83 strobe, msg_err_o stays 0.
- Bytes 00,FF,A5,34,12,84 -> leading 00,FF ignored; checksum mismatch -> one msg_err_o pulse, angle_valid_o stays 0, busy_o low afterwards.
- A5,34 then no byte for TIMEOUT_CYC cycles -> msg_err_o pulse at the timeout; a following clean A5,CD,AB,C3 -> angle_o = 16'hABCD.
- angle_ready_i = 0: A5,34,12,83 then A5,78,56,8B -> first word 1234 held, second frame rejected with msg_err_o pulse. Then raise angle_ready_i -> 1234 consumed and angle_valid_o drops.
- A5,34 with rx_err_i = 1 on the 34 strobe -> msg_err_o pulse, return to IDLE, no output. Also: assert rst_ni = 0 after A5,34 -> all outputs 0 immediately; after release, A5,34,12,83 yields 1234.
- Commit in the same cycle as a handshake (angle_valid_o = 1, angle_ready_i = 1 on the checksum strobe) -> new word loads, angle_valid_o stays 1, no error.
